// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receive engine with runtime-programmable frame format.
//   - 5..DATA_W_MAX data bits, optional odd/even parity, 1 or 2 stop bits.
//   - Mid-bit sampling from a CPB_W-bit clocks-per-bit divisor.
//   - Detects start-bit glitches, framing errors and breaks.
//   - Holds one frame behind a valid/ready handshake.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   rx               asynchronous serial line, idle high
//   brr_valid        strobe: load clk_per_bit into the divisor register
//   clk_per_bit      clocks per bit (values below 4 act as 4)
//   ctrl_valid       strobe: load data_len/parity_en/parity_odd/stop2
//   data_len         data bits, clamped to 5..DATA_W_MAX
//   parity_en        parity bit present
//   parity_odd       1 = odd parity, 0 = even parity
//   stop2            two stop bits
//   rx_data          received data, LSB first, unused upper bits 0
//   rx_parity_err    parity error (qualified by rx_valid)
//   rx_frame_err     framing error (qualified by rx_valid)
//   rx_break         break detected (qualified by rx_valid)
//   rx_valid         holding register full
//   rx_ready         consumer accepts the held frame
//   overrun          one-cycle pulse when a completed frame is dropped
//   busy             a frame is in progress
//
// Handshake: a frame transfers on every cycle where rx_valid && rx_ready.
// rx_valid stays high until that happens; rx_data and the flags are stable
// while rx_valid is high and keep their last values after it drops.
module uart_rx_core #(
  parameter int          DATA_W_MAX  = 9,
  parameter int          CPB_W       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned CPB_RST     = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  brr_valid,
  input  logic [CPB_W-1:0]      clk_per_bit,
  input  logic                  ctrl_valid,
  input  logic [3:0]            data_len,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  output logic [DATA_W_MAX-1:0] rx_data,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_break,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_PARITY    = 3'd4;
  localparam logic [2:0] S_STOP1     = 3'd5;
  localparam logic [2:0] S_STOP2     = 3'd6;

  localparam logic [CPB_W-1:0] CPB_MIN  = CPB_W'(4);
  localparam logic [CPB_W-1:0] CPB_ONE  = CPB_W'(1);
  localparam logic [CPB_W-1:0] CPB_INIT = CPB_W'(CPB_RST);
  localparam logic [3:0]       LEN_MAX  = 4'(DATA_W_MAX);

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l < 4'd5)         return 4'd5;
    else if (l > LEN_MAX) return LEN_MAX;
    else                  return l;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchroniser. Stages reset to 1 (idle line). prime_q marks when
  // the reset ones have been flushed out, so rxs reflects the real line;
  // until then WAIT_IDLE must not trust rxs==1.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   rxs;
  logic                   primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign primed = prime_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Programmable divisor and frame format, loadable in any state.
  // ---------------------------------------------------------------------
  logic [CPB_W-1:0] cpb_q;
  logic [3:0]       len_q;
  logic             pe_q, po_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpb_q <= CPB_INIT;
      len_q <= clamp_len(4'd8);
      pe_q  <= 1'b0;
      po_q  <= 1'b0;
      s2_q  <= 1'b0;
    end else begin
      if (brr_valid) cpb_q <= clk_per_bit;
      if (ctrl_valid) begin
        len_q <= clamp_len(data_len);
        pe_q  <= parity_en;
        po_q  <= parity_odd;
        s2_q  <= stop2;
      end
    end
  end

  logic [CPB_W-1:0] cpb_eff;
  assign cpb_eff = (cpb_q < CPB_MIN) ? CPB_MIN : cpb_q;

  // ---------------------------------------------------------------------
  // Receive FSM. Config is snapshotted at start detection so a register
  // write mid-frame only affects the next frame.
  // ---------------------------------------------------------------------
  logic [2:0]            state;
  logic [CPB_W-1:0]      cnt;
  logic [CPB_W-1:0]      cpb_s;
  logic [3:0]            len_s;
  logic                  pe_s, po_s, s2_s;
  logic [3:0]            bit_cnt;
  logic [DATA_W_MAX-1:0] shreg;
  logic                  par_bit;
  logic                  perr_q;

  logic                  sampling;
  logic                  tick;
  logic                  complete;
  logic                  frame_err_c;
  logic                  break_c;
  logic [DATA_W_MAX-1:0] data_aligned;

  assign sampling = (state == S_START) || (state == S_DATA) || (state == S_PARITY) ||
                    (state == S_STOP1) || (state == S_STOP2);
  assign tick     = sampling && (cnt == '0);

  // Data enters at the MSB and shifts down, so after len_s samples the
  // frame sits in the top len_s bits; realign it to bit 0 on output.
  assign data_aligned = shreg >> (LEN_MAX - len_s);

  always_comb begin
    complete    = 1'b0;
    frame_err_c = ~rxs;
    if (tick && (state == S_STOP1) && (!s2_s || !rxs)) complete = 1'b1;
    if (tick && (state == S_STOP2))                    complete = 1'b1;
    // Completion only happens on a stop sample, and a stop sample reaches
    // STOP2 only if STOP1 was good, so the current sample decides ferr.
    break_c = frame_err_c && (shreg == '0) && !(pe_s && par_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_WAIT_IDLE;
      cnt     <= '0;
      cpb_s   <= CPB_MIN;
      len_s   <= 4'd8;
      pe_s    <= 1'b0;
      po_s    <= 1'b0;
      s2_s    <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (sampling) cnt <= tick ? (cpb_s - CPB_ONE) : (cnt - CPB_ONE);

      case (state)
        S_WAIT_IDLE: if (primed && rxs) state <= S_IDLE;
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            cpb_s   <= cpb_eff;
            len_s   <= len_q;
            pe_s    <= pe_q;
            po_s    <= po_q;
            s2_s    <= s2_q;
            // Sample lands (cpb>>1) cycles after detection: the cycle
            // where cnt reaches 0 is itself the sample.
            cnt     <= (cpb_eff >> 1) - CPB_ONE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
          end
        end
        S_START: if (tick) state <= rxs ? S_IDLE : S_DATA;
        S_DATA: begin
          if (tick) begin
            shreg   <= {rxs, shreg[DATA_W_MAX-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == len_s - 4'd1) state <= pe_s ? S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          if (tick) begin
            par_bit <= rxs;
            perr_q  <= rxs != ((^shreg) ^ po_s);
            state   <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (tick) begin
            if (complete) state <= rxs ? S_IDLE : S_WAIT_IDLE;
            else          state <= S_STOP2;
          end
        end
        S_STOP2: if (tick) state <= rxs ? S_IDLE : S_WAIT_IDLE;
        default: state <= S_WAIT_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) && (state != S_WAIT_IDLE);

  // ---------------------------------------------------------------------
  // Holding register. A completing frame may replace the held one in the
  // same cycle the consumer takes it; otherwise it is dropped.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= data_aligned;
          rx_parity_err <= perr_q;
          rx_frame_err  <= frame_err_c;
          rx_break      <= break_c;
          rx_valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        brr_valid = 1'b0;
  logic [15:0] clk_per_bit = 16'd16;
  logic        ctrl_valid = 1'b0;
  logic [3:0]  data_len = 4'd8;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [8:0]  rx_data;
  logic        rx_parity_err, rx_frame_err, rx_break, rx_valid;
  logic        rx_ready = 1'b0;
  logic        overrun, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  uart_rx_core dut (
    .clk(clk), .rst(rst), .rx(rx),
    .brr_valid(brr_valid), .clk_per_bit(clk_per_bit),
    .ctrl_valid(ctrl_valid), .data_len(data_len),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .busy(busy)
  );

  // monitor: cycle count, rx_valid rising edges, overrun pulses
  int         cyc = 0;
  int         rises = 0;
  int         rise_cyc = 0;
  int         ovr_cnt = 0;
  int         fall_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [8:0] cap_data = '0;
  logic       cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx_valid && !prev_valid) begin
      rises++;
      rise_cyc = cyc;
      cap_data = rx_data;
      cap_perr = rx_parity_err;
      cap_ferr = rx_frame_err;
      cap_brk  = rx_break;
    end
    prev_valid = rx_valid;
    if (overrun) ovr_cnt++;
  end

  // driver tasks
  task automatic set_cfg(input int cpb, input int len, input bit pe, input bit podd, input bit s2);
    @(negedge clk);
    brr_valid   = 1'b1;
    clk_per_bit = 16'(cpb);
    ctrl_valid  = 1'b1;
    data_len    = 4'(len);
    parity_en   = pe;
    parity_odd  = podd;
    stop2       = s2;
    @(negedge clk);
    brr_valid   = 1'b0;
    ctrl_valid  = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int cpb);
    rx = b;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int len, input bit pe, input bit podd,
                            input bit pflip, input bit s2, input int cpb);
    logic p;
    p = podd ^ pflip;
    for (int i = 0; i < len; i++) p = p ^ d[i];
    @(negedge clk);
    fall_cyc = cyc;
    drive_bit(1'b0, cpb);
    for (int i = 0; i < len; i++) drive_bit(d[i], cpb);
    if (pe) drive_bit(p, cpb);
    drive_bit(1'b1, cpb);
    if (s2) drive_bit(1'b1, cpb);
  endtask

  // tests
  task automatic test_reset;
    int r0;
    rx  = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    r0  = rises;
    @(posedge clk); #2;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 9'h000) begin n_bad++; $display("FAIL reset_data: got %h want 000", rx_data); end
    n_cmp++; if ({rx_parity_err, rx_frame_err, rx_break} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {rx_parity_err, rx_frame_err, rx_break}); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL low_after_reset_busy: got %b want 0", busy); end
    n_cmp++; if (rises - r0 !== 0) begin n_bad++; $display("FAIL low_after_reset_frames: got %0d want 0", rises - r0); end
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_8n1;
    int r0;
    set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
    rx_ready = 1'b1;
    r0 = rises;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL 8n1_count: got %0d want 1", rises - r0); end
    n_cmp++; if (rise_cyc - fall_cyc !== 155) begin n_bad++; $display("FAIL 8n1_latency: got %0d want 155", rise_cyc - fall_cyc); end
    n_cmp++; if (cap_data !== 9'h0A5) begin n_bad++; $display("FAIL 8n1_data: got %h want 0a5", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b000) begin n_bad++; $display("FAIL 8n1_flags: got %b want 000", {cap_perr, cap_ferr, cap_brk}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL 8n1_busy: got %b want 0", busy); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL 8n1_consumed: got %b want 0", rx_valid); end
  endtask

  task automatic test_parity;
    int r0;
    set_cfg(16, 7, 1'b1, 1'b0, 1'b0);
    r0 = rises;
    send_frame(9'h035, 7, 1'b1, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL par_ok_count: got %0d want 1", rises - r0); end
    n_cmp++; if (rise_cyc - fall_cyc !== 155) begin n_bad++; $display("FAIL par_ok_latency: got %0d want 155", rise_cyc - fall_cyc); end
    n_cmp++; if (cap_data !== 9'h035) begin n_bad++; $display("FAIL par_ok_data: got %h want 035", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr} !== 2'b00) begin n_bad++; $display("FAIL par_ok_flags: got %b want 00", {cap_perr, cap_ferr}); end
    send_frame(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 2) begin n_bad++; $display("FAIL par_bad_count: got %0d want 2", rises - r0); end
    n_cmp++; if (cap_data !== 9'h035) begin n_bad++; $display("FAIL par_bad_data: got %h want 035", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr} !== 2'b10) begin n_bad++; $display("FAIL par_bad_flags: got %b want 10", {cap_perr, cap_ferr}); end
  endtask

  task automatic test_odd_cpb;
    int r0;
    set_cfg(5, 9, 1'b1, 1'b1, 1'b1);
    r0 = rises;
    send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b0, 1'b1, 5);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL cpb5_count: got %0d want 1", rises - r0); end
    n_cmp++; if (rise_cyc - fall_cyc !== 65) begin n_bad++; $display("FAIL cpb5_latency: got %0d want 65", rise_cyc - fall_cyc); end
    n_cmp++; if (cap_data !== 9'h1C3) begin n_bad++; $display("FAIL cpb5_data: got %h want 1c3", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b000) begin n_bad++; $display("FAIL cpb5_flags: got %b want 000", {cap_perr, cap_ferr, cap_brk}); end
    set_cfg(2, 9, 1'b1, 1'b1, 1'b1);
    send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b0, 1'b1, 4);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 2) begin n_bad++; $display("FAIL cpb2_count: got %0d want 2", rises - r0); end
    n_cmp++; if (rise_cyc - fall_cyc !== 53) begin n_bad++; $display("FAIL cpb2_latency: got %0d want 53", rise_cyc - fall_cyc); end
    n_cmp++; if (cap_data !== 9'h1C3) begin n_bad++; $display("FAIL cpb2_data: got %h want 1c3", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b000) begin n_bad++; $display("FAIL cpb2_flags: got %b want 000", {cap_perr, cap_ferr, cap_brk}); end
  endtask

  task automatic test_glitch;
    int r0;
    set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
    r0 = rises;
    @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start_busy: got %b want 1", busy); end
    rx = 1'b1;
    repeat (14) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got %b want 0", busy); end
    n_cmp++; if (rises - r0 !== 0) begin n_bad++; $display("FAIL glitch_no_frame: got %0d want 0", rises - r0); end
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL glitch_next_count: got %0d want 1", rises - r0); end
    n_cmp++; if (cap_data !== 9'h05A) begin n_bad++; $display("FAIL glitch_next_data: got %h want 05a", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b000) begin n_bad++; $display("FAIL glitch_next_flags: got %b want 000", {cap_perr, cap_ferr, cap_brk}); end
  endtask

  task automatic test_break;
    int r0;
    r0 = rises;
    @(negedge clk);
    rx = 1'b0;
    repeat (320) @(negedge clk);
    n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL break_count: got %0d want 1", rises - r0); end
    n_cmp++; if (cap_data !== 9'h000) begin n_bad++; $display("FAIL break_data: got %h want 000", cap_data); end
    n_cmp++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b011) begin n_bad++; $display("FAIL break_flags: got %b want 011", {cap_perr, cap_ferr, cap_brk}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL break_wait_idle: got %b want 0", busy); end
    rx = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL break_no_extra: got %0d want 1", rises - r0); end
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if (rises - r0 !== 2) begin n_bad++; $display("FAIL break_next_count: got %0d want 2", rises - r0); end
    n_cmp++; if ({cap_data, cap_brk} !== {9'h03C, 1'b0}) begin n_bad++; $display("FAIL break_next_data: got %h/%b want 03c/0", cap_data, cap_brk); end
  endtask

  task automatic test_back_to_back;
    int o0, r0;
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 9'h011}) begin n_bad++; $display("FAIL hold_first: got %b/%h want 1/011", rx_valid, rx_data); end
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 9'h011}) begin n_bad++; $display("FAIL hold_keep: got %b/%h want 1/011", rx_valid, rx_data); end
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - o0); end
    // consumer accepts in the completion cycle of the next frame
    o0 = ovr_cnt;
    fork
      send_frame(9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      begin
        repeat (155) @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk); #2;
        rx_ready = 1'b0;
        n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 9'h033}) begin n_bad++; $display("FAIL replace_data: got %b/%h want 1/033", rx_valid, rx_data); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL replace_overrun: got %b want 0", overrun); end
      end
    join
    repeat (5) @(negedge clk);
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL replace_no_overrun: got %0d want 0", ovr_cnt - o0); end
    // reset in the middle of a frame
    r0 = rises;
    fork
      send_frame(9'h00F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      begin
        repeat (105) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        n_cmp++; if ({rx_valid, rx_data} !== {1'b0, 9'h000}) begin n_bad++; $display("FAIL midrst_out: got %b/%h want 0/000", rx_valid, rx_data); end
        n_cmp++; if ({busy, overrun, rx_parity_err, rx_frame_err, rx_break} !== 5'b00000) begin n_bad++; $display("FAIL midrst_flags: got %b want 00000", {busy, overrun, rx_parity_err, rx_frame_err, rx_break}); end
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    n_cmp++; if (rises - r0 !== 0) begin n_bad++; $display("FAIL midrst_no_frame: got %0d want 0", rises - r0); end
    n_cmp++; if ({rx_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_idle: got %b want 00", {rx_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_odd_cpb();
    test_glitch();
    test_break();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine that replaces fixed 8-bit RX paths. It supports runtime-programmable frame formats: data length, parity mode and stop bits. It performs 16-bit divisor mid-bit sampling, detects glitches, framing errors and breaks, and holds one received frame behind a valid/ready handshake. It sits between the rx pin and the RX FIFO/APB register block, and takes its config strobes from the same brr_valid/ctrl_valid path as the existing TX.

Parameters:
DATA_W_MAX, 9, widest supported data field (minimum 5)
CPB_W, 16, width of the clock-per-bit divisor
SYNC_STAGES, 2, rx input synchroniser depth (minimum 2)
CPB_RST, 434, divisor value after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx  input  1  serial line, asynchronous, idle high
brr_valid  input  1  load strobe for clk_per_bit
clk_per_bit  input  CPB_W  clocks per bit; values below 4 are treated as 4
ctrl_valid  input  1  load strobe for the frame-format fields
data_len  input  4  data bits; values below 5 clamp to 5, values above DATA_W_MAX clamp to DATA_W_MAX
parity_en  input  1  parity bit present
parity_odd  input  1  1 = odd parity, 0 = even parity
stop2  input  1  two stop bits
rx_data  output  DATA_W_MAX  received data, LSB first, unused upper bits 0
rx_parity_err  output  1  qualified by rx_valid
rx_frame_err  output  1  qualified by rx_valid
rx_break  output  1  qualified by rx_valid
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts the frame
overrun  output  1  one-cycle pulse: a frame was dropped
busy  output  1  FSM not in IDLE or WAIT_IDLE

Behaviour:
- Reset:
  - All synchroniser stages = 1.
  - Divisor register = CPB_RST.
  - Format register = 8N1 (data_len 8, parity_en 0, parity_odd 0, stop2 0).
  - FSM = WAIT_IDLE.
  - rx_data = 0, all flags = 0, rx_valid = 0, overrun = 0, busy = 0.
- Reset mid-frame aborts the frame with no output. A line held low through reset is never taken as a start bit.
- Config loading:
  - Divisor and format registers load on their strobes in any state.
  - The FSM snapshots both registers at start detection, so an in-flight frame is unaffected.
- Sampling:
  - rxs = rx after SYNC_STAGES flops.
  - Down-counter cnt.
  - Start sample at (cpb>>1) cycles after detection.
  - Each later sample exactly cpb cycles after the previous sample.
- FSM:
  - WAIT_IDLE: go to IDLE when rxs==1.
  - IDLE: rxs==0 -> START; snapshot config; cnt = cpb>>1.
  - START: at the sample, rxs==1 -> IDLE (glitch, no output); otherwise -> DATA with bit index 0.
  - DATA: shift in LSB first; after data_len samples -> PARITY if enabled, otherwise STOP1.
  - PARITY:
    - Expected bit = XOR(data) ^ parity_odd.
    - A mismatch sets the parity error.
    - -> STOP1.
  - STOP1:
    - rxs==0 sets the frame error.
    - If stop2 and no error -> STOP2; otherwise complete.
  - STOP2: rxs==0 sets the frame error; then complete.
  - Completion: go to IDLE if the last sample was 1, otherwise WAIT_IDLE.
- Break: frame error with all data bits 0 and the parity bit 0 (if present). rx_break = 1 and rx_frame_err = 1.
- Latency: rx_valid rises the cycle after the final stop sample. From the rx falling edge this is SYNC_STAGES + (cpb>>1) + (data_len + parity_en + 1 + stop2)*cpb + 1 cycles.
- Holding register:
  - On completion, load data and flags if rx_valid==0, or if rx_valid&&rx_ready in the same cycle. rx_valid stays 1 in the latter case with no overrun.
  - Otherwise drop the new frame, keep the old contents and pulse overrun for 1 cycle.
  - rx_valid && rx_ready with no completion -> rx_valid = 0. rx_data and flags hold their last values.
- Arithmetic: cnt is CPB_W bits. The clamp to 4 is applied at snapshot. An odd cpb gives a half-bit of floor(cpb/2).

Test Plan:
1. cpb=16, 8N1, rx byte 0xA5, rx_ready=1 -> rx_data=0x0A5, rx_valid exactly 155 cycles after the falling edge, all error flags 0, busy low after completion.
2. cpb=16, 7E1, 0x35 sent with a correct parity bit, then with an inverted parity bit -> 0x035 with rx_parity_err 0, then 0x035 with rx_parity_err 1; rx_frame_err 0 both times.
3. cpb=5 (odd) then cpb=2 (clamped to 4); format 9O2, data 0x1C3 -> rx_data=0x1C3, no errors; cpb=4 timing matches the latency formula.
4. cpb=16, rx low for 6 cycles then high -> no rx_valid, FSM back in IDLE; a valid 0x5A frame immediately after is received correctly.
5. cpb=16, 8N1, rx low for 20 bit times -> exactly one rx_valid with rx_data=0, rx_frame_err=1, rx_break=1. No further frame until rx goes high and falls again.
6. rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x011 and overrun pulses once. Next, rx_ready=1 in the completion cycle of a frame 0x33 -> 0x033 loaded, no overrun. Finally, rst asserted mid-frame -> outputs 0, no rx_valid from the remainder of that frame.
